// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory and decode handshake bundle for fetch_sequencer
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  modport master (output imem_addr, inst_valid, inst, inst_pc, input imem_data, inst_ready);
  modport slave  (input imem_addr, inst_valid, inst, inst_pc, output imem_data, inst_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch FSM + prefetch FIFO with redirect flush; stall counter under FETCH_STALL_CNT_EN
module fetch_sequencer #(
  parameter int              ADDR_W   = 16,
  parameter int              INST_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  fetch_sequencer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic              pop, push, full, last;
  assign full            = count == (PW+1)'(DEPTH);
  assign pop             = bus.inst_valid & bus.inst_ready;
  assign push            = (state == RUN) & en & ~redirect & (~full | pop);
  assign last            = count == (PW+1)'(pop);
  assign bus.inst_valid  = count != '0;
  assign bus.inst        = bus.inst_valid ? mem_inst[rd_ptr] : '0;
  assign bus.inst_pc     = bus.inst_valid ? mem_pc[rd_ptr] : '0;
  assign bus.imem_addr   = fetch_pc;
  assign busy            = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= (state == DRAIN) ? IDLE : state;
    end else begin
      fetch_pc <= push ? fetch_pc + 1'b1 : fetch_pc;
      wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      state    <= (state == IDLE) ? (en ? RUN : IDLE) :
                  (state == RUN)  ? (en ? RUN : DRAIN) :
                  en ? RUN : last ? IDLE : DRAIN;
    end
  end
  // storage needs no reset: empty FIFO masks head contents to zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= bus.imem_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (state == RUN && bus.inst_ready && !bus.inst_valid && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule
